// File: rtl/lamp_mode_controller.sv
// Lamp mode controller: runs the lamp automatically from the presence sensor
// (with an off-delay) or manually from button presses. The classifier's long
// press moves between the two modes. Outputs are registered copies of the mode
// state, so they change one clock after the event that caused them.
module lamp_mode_controller #(
  parameter logic [15:0] OFF_DELAY      = 16'd30000,
  parameter logic [23:0] MANUAL_TIMEOUT = 24'd0,
  parameter int          CNT_W          = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic presence,
  output logic lamp,
  output logic manual,
  output logic hold
);

  typedef enum logic [2:0] {
    AUTO_OFF  = 3'd0,
    AUTO_ON   = 3'd1,
    AUTO_HOLD = 3'd2,
    MAN_OFF   = 3'd3,
    MAN_ON    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] OFF_LOAD   = CNT_W'(OFF_DELAY - 16'd1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(MANUAL_TIMEOUT - 24'd1);
  localparam logic [CNT_W-1:0] IDLE_MAX   = '1;
  localparam logic             TIMEOUT_EN = (MANUAL_TIMEOUT != 24'd0);

  state_t           state;
  state_t           state_nxt;
  logic             pres_m;
  logic             pres_s;
  logic             a_prev;
  logic             b_prev;
  logic [CNT_W-1:0] off_tmr;
  logic [CNT_W-1:0] idle_tmr;
  logic             long_ev;
  logic             short_ev;
  logic             in_man;
  logic             idle_done;

  // A long press is the rising edge of A. A short press is B falling while A
  // stays low, so a press that carries on into a long press never toggles.
  assign long_ev   = A & ~a_prev;
  assign short_ev  = b_prev & ~B & ~A;
  assign in_man    = (state == MAN_OFF) || (state == MAN_ON);
  assign idle_done = TIMEOUT_EN && (idle_tmr == IDLE_LAST);

  // Synchronise the raw presence pin and remember last cycle's button levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_m <= 1'b0;
      pres_s <= 1'b0;
      a_prev <= 1'b0;
      b_prev <= 1'b0;
    end else begin
      pres_m <= presence;
      pres_s <= pres_m;
      a_prev <= A;
      b_prev <= B;
    end
  end

  // Pick the next mode. Priority is long press, then short press, then manual
  // timeout, then presence, then off-delay expiry.
  always_comb begin
    state_nxt = AUTO_OFF;
    case (state)
      AUTO_OFF: begin
        if (long_ev)     state_nxt = MAN_OFF;
        else if (pres_s) state_nxt = AUTO_ON;
        else             state_nxt = AUTO_OFF;
      end
      AUTO_ON: begin
        if (long_ev)      state_nxt = MAN_ON;
        else if (!pres_s) state_nxt = AUTO_HOLD;
        else              state_nxt = AUTO_ON;
      end
      AUTO_HOLD: begin
        if (long_ev)              state_nxt = MAN_ON;
        else if (pres_s)          state_nxt = AUTO_ON;
        else if (off_tmr == '0)   state_nxt = AUTO_OFF;
        else                      state_nxt = AUTO_HOLD;
      end
      MAN_OFF: begin
        if (long_ev || (!short_ev && idle_done))
          state_nxt = pres_s ? AUTO_ON : AUTO_OFF;
        else if (short_ev) state_nxt = MAN_ON;
        else               state_nxt = MAN_OFF;
      end
      MAN_ON: begin
        if (long_ev || (!short_ev && idle_done))
          state_nxt = pres_s ? AUTO_ON : AUTO_OFF;
        else if (short_ev) state_nxt = MAN_OFF;
        else               state_nxt = MAN_ON;
      end
      default: state_nxt = AUTO_OFF;
    endcase
  end

  // Register the mode, its decoded outputs and both timers. The idle timer is
  // held at zero outside manual mode, so entering manual always starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= AUTO_OFF;
      lamp     <= 1'b0;
      manual   <= 1'b0;
      hold     <= 1'b0;
      off_tmr  <= '0;
      idle_tmr <= '0;
    end else begin
      state  <= state_nxt;
      lamp   <= (state_nxt == AUTO_ON) || (state_nxt == AUTO_HOLD) ||
                (state_nxt == MAN_ON);
      manual <= (state_nxt == MAN_OFF) || (state_nxt == MAN_ON);
      hold   <= (state_nxt == AUTO_HOLD);

      if ((state == AUTO_ON) && (state_nxt == AUTO_HOLD))
        off_tmr <= OFF_LOAD;
      else if ((state == AUTO_HOLD) && (state_nxt == AUTO_HOLD) && (off_tmr != '0))
        off_tmr <= off_tmr - ONE;

      if (!in_man || long_ev || short_ev)
        idle_tmr <= '0;
      else if (idle_tmr != IDLE_MAX)
        idle_tmr <= idle_tmr + ONE;
    end
  end

endmodule

// File: tb/tb_lamp_mode_controller.sv
// Testbench for lamp_mode_controller: two instances (manual timeout 20 and
// disabled) run side by side against a behavioural model of the lamp modes.
module tb_lamp_mode_controller;

  localparam int OFF_DELAY_I = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       b;
  logic       presence;
  logic [1:0] lamp_v;
  logic [1:0] manual_v;
  logic [1:0] hold_v;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference model: per instance, whether manual mode is active, whether the
  // lamp is lit, how many off-delay cycles remain (0 = not holding) and how
  // many idle cycles have passed in manual mode.
  int mto [2];
  bit m_man [2];
  bit m_lamp [2];
  int m_hold_left [2];
  int m_idle [2];
  bit m_aprev;
  bit m_bprev;
  bit m_pipe [2];

  typedef struct {
    logic a;
    logic b;
    logic p;
    logic lamp;
    logic manual;
    logic hold;
  } vec_t;

  vec_t vecs [15];

  // Free-running clock.
  always #5 clk = ~clk;

  lamp_mode_controller #(
    .OFF_DELAY(16'd8),
    .MANUAL_TIMEOUT(24'd20),
    .CNT_W(24)
  ) dut_to (
    .clk(clk),
    .rst(rst),
    .A(a),
    .B(b),
    .presence(presence),
    .lamp(lamp_v[0]),
    .manual(manual_v[0]),
    .hold(hold_v[0])
  );

  lamp_mode_controller #(
    .OFF_DELAY(16'd8),
    .MANUAL_TIMEOUT(24'd0),
    .CNT_W(24)
  ) dut_nt (
    .clk(clk),
    .rst(rst),
    .A(a),
    .B(b),
    .presence(presence),
    .lamp(lamp_v[1]),
    .manual(manual_v[1]),
    .hold(hold_v[1])
  );

  task automatic check_output(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0b required=%0b", name, cycle, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_man[k]       = 1'b0;
      m_lamp[k]      = 1'b0;
      m_hold_left[k] = 0;
      m_idle[k]      = 0;
    end
    m_aprev   = 1'b0;
    m_bprev   = 1'b0;
    m_pipe[0] = 1'b0;
    m_pipe[1] = 1'b0;
  endtask

  // One clock of the model, using the input levels present at the edge.
  task automatic model_step();
    bit long_ev;
    bit short_ev;
    bit ps;
    long_ev  = a && !m_aprev;
    short_ev = m_bprev && !b && !a;
    ps       = m_pipe[1];
    for (int k = 0; k < 2; k++) begin
      if (m_man[k]) begin
        if (long_ev || (!short_ev && mto[k] != 0 && m_idle[k] + 1 == mto[k])) begin
          m_man[k]       = 1'b0;
          m_lamp[k]      = ps;
          m_hold_left[k] = 0;
          m_idle[k]      = 0;
        end else if (short_ev) begin
          m_lamp[k] = !m_lamp[k];
          m_idle[k] = 0;
        end else begin
          m_idle[k]++;
        end
      end else if (long_ev) begin
        m_man[k]       = 1'b1;
        m_hold_left[k] = 0;
        m_idle[k]      = 0;
      end else if (!m_lamp[k]) begin
        if (ps) m_lamp[k] = 1'b1;
      end else if (m_hold_left[k] == 0) begin
        if (!ps) m_hold_left[k] = OFF_DELAY_I;
      end else if (ps) begin
        m_hold_left[k] = 0;
      end else if (m_hold_left[k] == 1) begin
        m_hold_left[k] = 0;
        m_lamp[k]      = 1'b0;
      end else begin
        m_hold_left[k]--;
      end
    end
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = presence;
    m_aprev   = a;
    m_bprev   = b;
  endtask

  task automatic apply_stimulus(input logic a_v, input logic b_v, input logic p_v);
    a        = a_v;
    b        = b_v;
    presence = p_v;
  endtask

  // Advance one clock and compare both instances against the model.
  task automatic tick();
    @(posedge clk);
    model_step();
    cycle++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("lamp[%0d]", k), lamp_v[k], m_lamp[k]);
      check_output($sformatf("manual[%0d]", k), manual_v[k], m_man[k]);
      check_output($sformatf("hold[%0d]", k), hold_v[k], (!m_man[k] && m_hold_left[k] > 0));
    end
  endtask

  task automatic sync_reset_all();
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Assert reset between edges and check that outputs drop without a clock.
  task automatic async_reset(input string tag, input logic hold_a);
    #2;
    rst = 1'b1;
    apply_stimulus(hold_a, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("%s lamp[%0d]", tag, k), lamp_v[k], 1'b0);
      check_output($sformatf("%s manual[%0d]", tag, k), manual_v[k], 1'b0);
      check_output($sformatf("%s hold[%0d]", tag, k), hold_v[k], 1'b0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // After presence falls, measure when hold starts, how long it lasts and
  // when the lamp goes dark (bounded).
  task automatic measure_hold(output int first_hold, output int holds, output int fall);
    first_hold = 0;
    holds      = 0;
    fall       = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (hold_v[0]) begin
        holds++;
        if (first_hold == 0) first_hold = i;
      end
      if (!lamp_v[0]) begin
        fall = i;
        break;
      end
    end
  endtask

  // Timeout guard so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first_hold;
    int holds;
    int fall;
    int man_fall;
    bit stayed;

    mto[0] = 20;
    mto[1] = 0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_output("reset lamp", lamp_v[0], 1'b0);
    check_output("reset manual", manual_v[0], 1'b0);
    check_output("reset hold", hold_v[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed button table starting from a clean reset.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].p);
      tick();
      check_output($sformatf("vec%0d lamp", i), lamp_v[0], vecs[i].lamp);
      check_output($sformatf("vec%0d manual", i), manual_v[0], vecs[i].manual);
      check_output($sformatf("vec%0d hold", i), hold_v[0], vecs[i].hold);
    end

    // Presence latency and a full off-delay countdown.
    sync_reset_all();
    presence = 1'b1;
    tick();
    check_output("pres lat1 lamp", lamp_v[0], 1'b0);
    tick();
    check_output("pres lat2 lamp", lamp_v[0], 1'b0);
    tick();
    check_output("pres lat3 lamp", lamp_v[0], 1'b1);
    for (int i = 0; i < 5; i++) tick();
    presence = 1'b0;
    measure_hold(first_hold, holds, fall);
    check_int("hold start", first_hold, 3);
    check_int("hold cycles", holds, 8);
    check_int("lamp fall", fall, 11);

    // Presence returns part way through the countdown, then leaves again.
    presence = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    presence = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_output("mid hold", hold_v[0], 1'b1);
    presence = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_output("rehit hold", hold_v[0], 1'b0);
    check_output("rehit lamp", lamp_v[0], 1'b1);
    presence = 1'b0;
    measure_hold(first_hold, holds, fall);
    check_int("restart hold cycles", holds, 8);
    check_int("restart lamp fall", fall, 11);

    // Long press into manual, short press to light, then idle timeout.
    a = 1'b1;
    tick();
    check_output("long manual", manual_v[0], 1'b1);
    check_output("long lamp", lamp_v[0], 1'b0);
    a = 1'b0;
    tick();
    b = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    b = 1'b0;
    tick();
    check_output("short lamp", lamp_v[0], 1'b1);
    man_fall = 0;
    stayed   = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (man_fall == 0 && !manual_v[0]) man_fall = i;
      if (!(manual_v[1] && lamp_v[1])) stayed = 1'b0;
    end
    check_int("timeout cycle", man_fall, 20);
    check_output("no timeout persists", stayed, 1'b1);

    // Reset during a countdown and during manual-on.
    sync_reset_all();
    presence = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    presence = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_output("pre-reset hold", hold_v[0], 1'b1);
    async_reset("rst hold", 1'b0);
    a = 1'b1;
    tick();
    a = 1'b0;
    tick();
    b = 1'b1;
    tick();
    b = 1'b0;
    tick();
    check_output("pre-reset man lamp", lamp_v[0], 1'b1);
    async_reset("rst man", 1'b1);
    tick();
    check_output("held A manual", manual_v[0], 1'b1);
    check_output("held A lamp", lamp_v[0], 1'b0);
    a = 1'b0;
    tick();

    // Random button and presence activity against the model.
    sync_reset_all();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) a = ~a;
      if ($urandom_range(5) == 0) b = ~b;
      if ($urandom_range(19) == 0) presence = ~presence;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lamp_mode_controller.md
Name: lamp_mode_controller

Overview:
- Main sequencer for the automatic lighting system. Consumes the button classifier's level outputs A (long-press level) and B (short-press level), plus a raw presence-sensor input.
- Drives the lamp in either automatic (presence plus off-delay) or manual (push-button toggle) mode.
- Sits between the button classifier / sensor front-end and the lamp driver output.

Parameters:
- OFF_DELAY, 16'd30000: cycles the lamp stays on in auto mode after synchronized presence falls; must be >= 1.
- MANUAL_TIMEOUT, 24'd0: cycles without a button event before manual mode auto-returns to auto mode; 0 disables the timeout.
- CNT_W, 24: width of the internal timers; must hold max(OFF_DELAY, MANUAL_TIMEOUT).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- A, input, 1: long-press level from the button classifier; high while the button is held past the long threshold.
- B, input, 1: short-press level from the button classifier; high while held past debounce but below the long threshold.
- presence, input, 1: raw, asynchronous presence sensor; active-high.
- lamp, output, 1: lamp drive; 1 = on.
- manual, output, 1: 1 = manual mode active.
- hold, output, 1: 1 = auto off-delay countdown in progress.

Behaviour:
- Reset (async): state AUTO_OFF; lamp=0, manual=0, hold=0; a_prev=b_prev=0; sync flops=0; off_tmr=0; idle_tmr=0.
- Presence sync: 2-flop synchronizer produces pres_s. A presence edge is visible in pres_s 2 clocks after it is sampled.
- Event decode (combinational, from registered a_prev/b_prev):
  - long_ev = A & ~a_prev.
  - short_ev = b_prev & ~B & ~A.
  - A B->A handover (press continues to long) is therefore not a short event. long_ev and short_ev are mutually exclusive.
- States: AUTO_OFF, AUTO_ON, AUTO_HOLD, MAN_OFF, MAN_ON. All transitions occur on the clk edge following the decode cycle.
- AUTO_OFF:
  - long_ev -> MAN_OFF.
  - else pres_s -> AUTO_ON.
  - short_ev ignored.
- AUTO_ON:
  - long_ev -> MAN_ON.
  - else ~pres_s -> AUTO_HOLD, load off_tmr = OFF_DELAY-1.
  - short_ev ignored.
- AUTO_HOLD:
  - long_ev -> MAN_ON.
  - else pres_s -> AUTO_ON.
  - else off_tmr==0 -> AUTO_OFF.
  - else off_tmr decrements.
  - Lamp is on for exactly OFF_DELAY cycles in AUTO_HOLD when presence stays low.
- MAN_OFF / MAN_ON:
  - short_ev toggles between MAN_OFF and MAN_ON.
  - long_ev -> AUTO_ON if pres_s, else AUTO_OFF.
  - idle_tmr clears on entry to manual and on any short_ev or long_ev; otherwise it increments, saturating.
  - If MANUAL_TIMEOUT != 0 and idle_tmr == MANUAL_TIMEOUT-1, exit to AUTO_ON if pres_s, else AUTO_OFF.
- Priority per cycle: long_ev > short_ev > manual timeout > presence > off_tmr expiry.
- Outputs are a Moore decode of the state register:
  - lamp = AUTO_ON | AUTO_HOLD | MAN_ON.
  - manual = MAN_OFF | MAN_ON.
  - hold = AUTO_HOLD.
  - Output latency: 1 clk after the event cycle; 3 clk after a presence pin change.
- Illegal or unused state encodings -> AUTO_OFF on the next clk.
- Reset mid-countdown or mid-manual: immediate AUTO_OFF and all outputs 0. A held A after reset release counts as a fresh long_ev, because a_prev is cleared to 0.
- Timers never wrap: off_tmr stops at 0, idle_tmr saturates at all-ones.

Test Plan (OFF_DELAY=8, MANUAL_TIMEOUT=20):
- Presence high at cycle 10, low at cycle 30:
  - lamp rises at cycle 13.
  - hold rises at cycle 33.
  - lamp and hold fall at cycle 41 (exactly 8 hold cycles).
- Presence re-asserts during AUTO_HOLD at hold cycle 4 -> back to AUTO_ON, hold=0, lamp stays 1. After presence falls again, a full 8-cycle countdown restarts.
- Long press (A 0->1, B 1->0 in the same cycle) from AUTO_OFF:
  - manual=1, lamp=0 one clk later.
  - No toggle occurs, because short_ev is not generated.
- In manual, B pulse high for 5 cycles then low with A=0 -> lamp toggles 0->1. A second short press toggles it back to 0.
- MAN_ON with no events for 20 cycles, presence low -> AUTO_OFF: manual=0, lamp=0 on the 20th cycle. With MANUAL_TIMEOUT=0, manual mode persists for 1000 cycles.
- Assert rst during AUTO_HOLD (off_tmr=5) and during MAN_ON -> lamp/manual/hold=0 immediately (async). Release rst with A held high -> enters MAN_OFF 1 clk later.
